door_lock_ctrl: RTL and testbench
=================================

// Module: door_lock_ctrl
// PURPOSE
//  Multi-door lock controller for the room terminal: drives N lock solenoids from unlock/lock
//  requests, the inside push-button, and the per-room booking flag. Adds request edge detection,
//  timed auto-relock and denied-request reporting. Sits between keypad/booking logic and the
//  solenoid drivers.
// PARAMETERS
//  N_DOORS     1           number of independent door channels
//  HOLD_CYCLES 50_000_000  clk cycles a timed unlock lasts (1 s at 50 MHz); must be >= 2
//  TW          $clog2(HOLD_CYCLES) relock timer width (derived, not overridden)
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-high reset
//  booked      in   N_DOORS  level: room booked, unlock requests refused
//  unlock_req  in   N_DOORS  level; rising edge requests timed unlock
//  lock_req    in   N_DOORS  level; rising edge forces immediate relock
//  pb_state    in   N_DOORS  level: inside push-button held; door held open, booking ignored
//  lock_output out  N_DOORS  1 = solenoid released (door openable), registered
//  denied      out  N_DOORS  1-cycle pulse: unlock edge refused because booked
//  all_locked  out  1        1 when every lock_output bit is 0, registered
// BEHAVIOUR
//  - One clock, synchronous active-high reset; all inputs synchronous to clk.
//  - Reset: state LOCKED, lock_output=0, denied=0, all_locked=1, timers=0.
//    Edge registers reset to 1, so a request held high through reset is not an edge.
//    Reset mid-unlock relocks on the next edge.
//  - Edge detect per channel: rise = req & ~req_q; req_q <= req each cycle.
//  - Per-channel FSM {LOCKED, OPEN_TIMED, OPEN_HELD}; lock_output = (state != LOCKED).
//    Latency 1: an input sampled at edge k changes lock_output after edge k.
//  - LOCKED:
//      pb_state                 -> OPEN_HELD
//      else unlock rise & ~booked -> OPEN_TIMED, timer <= HOLD_CYCLES-1
//      else unlock rise & booked  -> stay; denied pulses 1 cycle
//  - OPEN_TIMED, priority high to low:
//      pb_state     -> OPEN_HELD
//      lock rise    -> LOCKED
//      booked       -> LOCKED
//      unlock rise  -> reload timer to HOLD_CYCLES-1
//      timer==0     -> LOCKED
//      else         -> timer--
//    lock_output is therefore high for exactly HOLD_CYCLES cycles when undisturbed.
//  - OPEN_HELD: stay while pb_state; on pb_state low -> OPEN_TIMED, timer <= HOLD_CYCLES-1
//    (grace period). lock_req and booked are ignored while held (egress safety).
//  - Simultaneous unlock and lock rise in LOCKED: lock wins, stay LOCKED, no denied pulse.
//  - Timer never wraps: decrement only when timer != 0.
//  - Channels are fully independent.
//  - all_locked = ~|next lock_output, registered alongside lock_output.
// STRUCTURE
//  - door_lock_pkg: typedef enum logic [1:0] lock_state_t {LOCKED, OPEN_TIMED, OPEN_HELD};
//    localparam default HOLD_CYCLES.
//  - Sub-module door_lock_chan: one channel (edge regs, FSM, timer, denied).
//  - Top instantiates N_DOORS copies with a generate loop and reduces all_locked.
// TESTING (bench uses N_DOORS=2, HOLD_CYCLES=8)
//  1. Reset with unlock_req[0] held high, then release reset
//     -> no unlock; lock_output=00, all_locked=1.
//  2. unlock_req[0] 0->1, booked=0
//     -> lock_output[0]=1 for exactly 8 cycles starting the cycle after the edge, then 0;
//        ch1 stays 0.
//  3. booked[1]=1, unlock_req[1] rise
//     -> denied[1]=1 for one cycle; lock_output[1] stays 0.
//  4. Timed unlock on ch0, second unlock rise at count 5
//     -> open extends 8 cycles past the second edge; lock rise mid-window -> 0 the next cycle.
//  5. pb_state[0]=1 with booked[0]=1 for 20 cycles, plus a lock rise
//     -> lock_output[0] stays 1; after pb release it stays 1 for 8 more cycles.
//  6. Reset asserted in OPEN_TIMED
//     -> lock_output=0 the next cycle; simultaneous unlock+lock rise in LOCKED -> stays locked.

Source files
------------

// File: rtl/door_lock_pkg.sv
// Shared types and defaults for the room-terminal door lock controller.
package door_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED     = 2'd0,
    OPEN_TIMED = 2'd1,
    OPEN_HELD  = 2'd2
  } lock_state_t;

  // 1 s at 50 MHz
  localparam int HOLD_CYCLES_DEF = 50_000_000;

endpackage

// File: rtl/door_lock_chan.sv
// One door channel: request edge detection, lock FSM, auto-relock timer, denied pulse.
module door_lock_chan
  import door_lock_pkg::*;
#(
  parameter int  HOLD_CYCLES = HOLD_CYCLES_DEF,
  localparam int TW          = $clog2(HOLD_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic booked,
  input  logic unlock_req,
  input  logic lock_req,
  input  logic pb_state,
  output logic lock_output,
  output logic denied,
  output logic lock_nxt
);

  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

  lock_state_t   state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          denied_nxt;
  logic          unlock_q, lock_q;
  logic          unlock_rise, lock_rise;

  assign unlock_rise = unlock_req & ~unlock_q;
  assign lock_rise   = lock_req & ~lock_q;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    denied_nxt = 1'b0;
    case (state)
      LOCKED: begin
        if (pb_state) begin
          state_nxt = OPEN_HELD;
        end else if (lock_rise) begin
          // a lock edge beats a coincident unlock edge and suppresses denied
          state_nxt = LOCKED;
        end else if (unlock_rise) begin
          if (booked) begin
            denied_nxt = 1'b1;
          end else begin
            state_nxt = OPEN_TIMED;
            timer_nxt = RELOAD;
          end
        end
      end
      OPEN_TIMED: begin
        if (pb_state) begin
          state_nxt = OPEN_HELD;
        end else if (lock_rise || booked) begin
          state_nxt = LOCKED;
        end else if (unlock_rise) begin
          timer_nxt = RELOAD;
        end else if (timer == '0) begin
          state_nxt = LOCKED;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      OPEN_HELD: begin
        // lock_req and booked are ignored while someone is leaving
        if (!pb_state) begin
          state_nxt = OPEN_TIMED;
          timer_nxt = RELOAD;
        end
      end
      default: state_nxt = LOCKED;
    endcase
  end

  assign lock_nxt = (state_nxt != LOCKED);

  // Register stage: edge history, FSM state, timer and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOCKED;
      timer       <= '0;
      unlock_q    <= 1'b1;
      lock_q      <= 1'b1;
      lock_output <= 1'b0;
      denied      <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      unlock_q    <= unlock_req;
      lock_q      <= lock_req;
      lock_output <= lock_nxt;
      denied      <= denied_nxt;
    end
  end

endmodule

// File: rtl/door_lock_ctrl.sv
// Multi-door lock controller: N independent channels plus a registered all-locked summary.
module door_lock_ctrl
  import door_lock_pkg::*;
#(
  parameter int N_DOORS     = 1,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DOORS-1:0] booked,
  input  logic [N_DOORS-1:0] unlock_req,
  input  logic [N_DOORS-1:0] lock_req,
  input  logic [N_DOORS-1:0] pb_state,
  output logic [N_DOORS-1:0] lock_output,
  output logic [N_DOORS-1:0] denied,
  output logic               all_locked
);

  logic [N_DOORS-1:0] lock_nxt;

  for (genvar i = 0; i < N_DOORS; i++) begin : g_chan
    door_lock_chan #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .booked     (booked[i]),
      .unlock_req (unlock_req[i]),
      .lock_req   (lock_req[i]),
      .pb_state   (pb_state[i]),
      .lock_output(lock_output[i]),
      .denied     (denied[i]),
      .lock_nxt   (lock_nxt[i])
    );
  end

  // Built from next-state so it lines up with the registered lock_output bits
  always_ff @(posedge clk) begin
    if (reset) begin
      all_locked <= 1'b1;
    end else begin
      all_locked <= ~|lock_nxt;
    end
  end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Bench for door_lock_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_door_lock_ctrl;

  localparam int N = 2;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] booked, unlock_req, lock_req, pb_state;
  logic [N-1:0] lock_output, denied;
  logic         all_locked;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a door is open while held or while it has cycles of open time left.
  int rem    [N];
  bit held   [N];
  bit prev_u [N];
  bit prev_l [N];
  bit m_den  [N];

  door_lock_ctrl #(
    .N_DOORS    (N),
    .HOLD_CYCLES(H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .booked     (booked),
    .unlock_req (unlock_req),
    .lock_req   (lock_req),
    .pb_state   (pb_state),
    .lock_output(lock_output),
    .denied     (denied),
    .all_locked (all_locked)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < N; c++) begin
      bit ur, lr;
      ur = unlock_req[c] & ~prev_u[c];
      lr = lock_req[c] & ~prev_l[c];
      m_den[c] = 1'b0;
      if (reset) begin
        held[c]   = 1'b0;
        rem[c]    = 0;
        prev_u[c] = 1'b1;
        prev_l[c] = 1'b1;
      end else begin
        if (held[c]) begin
          if (!pb_state[c]) begin
            held[c] = 1'b0;
            rem[c]  = H;
          end
        end else if (rem[c] > 0) begin
          if (pb_state[c]) begin
            held[c] = 1'b1;
            rem[c]  = 0;
          end else if (lr || booked[c]) rem[c] = 0;
          else if (ur)                  rem[c] = H;
          else                          rem[c] = rem[c] - 1;
        end else begin
          if (pb_state[c])     held[c] = 1'b1;
          else if (lr)         rem[c]  = 0;
          else if (ur) begin
            if (booked[c]) m_den[c] = 1'b1;
            else           rem[c]   = H;
          end
        end
        prev_u[c] = unlock_req[c];
        prev_l[c] = lock_req[c];
      end
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] b, input logic [N-1:0] u,
                      input logic [N-1:0] l, input logic [N-1:0] p);
    logic [N-1:0] exp_lo, exp_den;
    @(negedge clk);
    reset      = r;
    booked     = b;
    unlock_req = u;
    lock_req   = l;
    pb_state   = p;
    @(posedge clk);
    model_update();
    #1;
    for (int c = 0; c < N; c++) begin
      exp_lo[c]  = held[c] || (rem[c] > 0);
      exp_den[c] = m_den[c];
    end
    chk_val("lock_output", 32'(lock_output), 32'(exp_lo));
    chk_val("denied", 32'(denied), 32'(exp_den));
    chk_val("all_locked", 32'(all_locked), 32'(exp_lo == '0));
  endtask

  initial begin
    int cnt0, cnt1, den_cnt;
    reset = 1'b1; booked = '0; unlock_req = '0; lock_req = '0; pb_state = '0;

    // 1: request held high through reset is not an edge
    step(1, 2'b00, 2'b01, 2'b00, 2'b00);
    step(1, 2'b00, 2'b01, 2'b00, 2'b00);
    step(0, 2'b00, 2'b01, 2'b00, 2'b00);
    step(0, 2'b00, 2'b01, 2'b00, 2'b00);
    chk_val("t1_locked", 32'(lock_output), 32'h0);
    chk_val("t1_all_locked", 32'(all_locked), 32'h1);

    // 2: timed unlock on ch0 lasts exactly H cycles
    step(0, 2'b00, 2'b00, 2'b00, 2'b00);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, 2'b00, 2'b01, 2'b00, 2'b00);
      cnt0 += int'(lock_output[0]);
      cnt1 += int'(lock_output[1]);
    end
    chk_val("t2_open_cycles", 32'(cnt0), 32'(H));
    chk_val("t2_ch1_closed", 32'(cnt1), 32'h0);

    // 3: booked room refuses unlock with a single denied pulse
    step(0, 2'b10, 2'b00, 2'b00, 2'b00);
    den_cnt = 0; cnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b10, 2'b10, 2'b00, 2'b00);
      den_cnt += int'(denied[1]);
      cnt1    += int'(lock_output[1]);
    end
    chk_val("t3_denied_pulses", 32'(den_cnt), 32'h1);
    chk_val("t3_ch1_closed", 32'(cnt1), 32'h0);

    // 4: retrigger at count 5 extends the window, then lock edge closes mid-window
    step(0, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b00, 2'b01, 2'b00, 2'b00);
    step(0, 2'b00, 2'b01, 2'b00, 2'b00);
    step(0, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b00, 2'b00, 2'b00, 2'b00);
    cnt0 = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 2'b00, 2'b01, 2'b00, 2'b00);
      cnt0 += int'(lock_output[0]);
    end
    chk_val("t4_extended", 32'(cnt0), 32'(H));
    step(0, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b00, 2'b01, 2'b00, 2'b00);
    step(0, 2'b00, 2'b01, 2'b00, 2'b00);
    step(0, 2'b00, 2'b01, 2'b01, 2'b00);
    chk_val("t4_lock_mid", 32'(lock_output[0]), 32'h0);

    // 5: push-button overrides booking and lock requests, then grace period
    step(0, 2'b01, 2'b00, 2'b00, 2'b00);
    cnt0 = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 2'b01, 2'b00, (i == 10) ? 2'b01 : 2'b00, 2'b01);
      cnt0 += int'(lock_output[0]);
    end
    chk_val("t5_held", 32'(cnt0), 32'd20);
    cnt0 = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 2'b00, 2'b00, 2'b00, 2'b00);
      cnt0 += int'(lock_output[0]);
    end
    chk_val("t5_grace", 32'(cnt0), 32'(H));

    // 6: reset mid-unlock relocks; coincident unlock+lock edge stays locked
    step(0, 2'b00, 2'b01, 2'b00, 2'b00);
    step(0, 2'b00, 2'b01, 2'b00, 2'b00);
    step(1, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_val("t6_reset_relock", 32'(lock_output), 32'h0);
    step(0, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 2'b00, 2'b11, 2'b11, 2'b00);
    chk_val("t6_both_locked", 32'(lock_output), 32'h0);
    chk_val("t6_no_denied", 32'(denied), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] rb, ru, rl, rp;
      for (int c = 0; c < N; c++) begin
        rb[c] = ($urandom_range(0, 5) == 0);
        ru[c] = ($urandom_range(0, 2) == 0);
        rl[c] = ($urandom_range(0, 9) == 0);
        rp[c] = ($urandom_range(0, 11) == 0);
      end
      step(($urandom_range(0, 99) == 0), rb, ru, rl, rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
